// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave transaction controller.
// Decodes the command byte, then sequences address, write-data and read-data
// phases, driving single-cycle strobes toward the datapath / register file.
// Optional macro SPI_CTRL_ERR_EN: adds a sticky protocol-error flag on Err
// (master overrun in DONE, or SS rising mid-transaction). Without it Err is 0.
module spi_slave_ctrl #(
   parameter int WIDTH = 8,
   parameter int LEN_W = WIDTH - 2
) (
   input  logic             SCLK,
   input  logic             RST,
   input  logic             SS,
   input  logic             counter_tick,
   input  logic [WIDTH-1:0] Data_sh,
   output logic             Address_en,
   output logic             Wr_Data_en,
   output logic             incr_sel,
   output logic             Rd_EN,
   output logic             Load_rd,
   output logic             Busy,
   output logic             Err
);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, WR_DATA, WR_INC, RD_DUMMY, RD_DATA, DONE
   } state_t;

   localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

   state_t           state;
   logic             cmd_wr;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       phase;   // cycles since last tick, 1 = cycle after tick, saturates at 3
   logic             live;    // out of reset and selected: strobes allowed

   assign live = RST & ~SS;

   // Transaction sequencing: command latch, byte countdown, intra-byte phase.
   always_ff @(posedge SCLK) begin
      if (!RST) begin
         state     <= IDLE;
         cmd_wr    <= 1'b0;
         remaining <= '0;
         phase     <= 2'd0;
      end else if (SS) begin
         // Deselect abandons everything, including a partial byte.
         state <= IDLE;
         phase <= 2'd0;
      end else begin
         if (counter_tick)
            phase <= 2'd1;
         else if (phase != 2'd3)
            phase <= phase + 2'd1;
         case (state)
            IDLE:     state <= CMD;
            CMD: if (counter_tick) begin
               cmd_wr    <= Data_sh[WIDTH-1];
               // Remaining = N-1: len for a burst, zero for a single byte.
               remaining <= Data_sh[WIDTH-2] ? Data_sh[LEN_W-1:0] : '0;
               state     <= ADDR;
            end
            ADDR: if (counter_tick)
               state <= cmd_wr ? WR_DATA : RD_DUMMY;
            WR_DATA: if (counter_tick)
               state <= (remaining == '0) ? DONE : WR_INC;
            WR_INC: begin
               remaining <= remaining - REM_ONE;
               state     <= WR_DATA;
            end
            RD_DUMMY: if (counter_tick)
               state <= RD_DATA;
            RD_DATA: if (counter_tick) begin
               if (remaining == '0)
                  state <= DONE;
               else
                  remaining <= remaining - REM_ONE;
            end
            DONE:     state <= DONE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Strobe decode from registered state/phase and the current tick.
   always_comb begin
      Address_en = 1'b0;
      Wr_Data_en = 1'b0;
      incr_sel   = 1'b0;
      Rd_EN      = 1'b0;
      Load_rd    = 1'b0;
      if (live) begin
         case (state)
            ADDR:    Address_en = counter_tick;
            WR_DATA: Wr_Data_en = counter_tick;
            // One cycle after Wr_Data_en so the registered write uses the old address.
            WR_INC:  incr_sel   = 1'b1;
            RD_DUMMY: begin
               // First read fetches the addressed register without incrementing.
               Rd_EN   = (phase == 2'd1) & ~counter_tick;
               Load_rd = counter_tick;
            end
            RD_DATA: if (remaining != '0) begin
               // Bump address, then fetch, so the next byte is ready by the tick.
               incr_sel = (phase == 2'd1) & ~counter_tick;
               Rd_EN    = (phase == 2'd2) & ~counter_tick;
               Load_rd  = counter_tick;
            end
            default: ;
         endcase
      end
   end

   assign Busy = RST & (state != IDLE);

`ifdef SPI_CTRL_ERR_EN
   logic err_q;

   // Sticky error: overrun tick in DONE or deselect mid-transaction.
   always_ff @(posedge SCLK) begin
      if (!RST)
         err_q <= 1'b0;
      else if (state == IDLE && !SS)
         err_q <= 1'b0;
      else if ((state == DONE && counter_tick) ||
               (SS && (state inside {ADDR, WR_DATA, WR_INC, RD_DUMMY, RD_DATA})))
         err_q <= 1'b1;
   end

   assign Err = RST & err_q;
`else
   assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed-vector bench for spi_slave_ctrl.
// Each byte is 4 SCLK cycles with counter_tick on the last one; strobes and
// Busy are checked every cycle against hand-derived vectors, and a tiny
// datapath address model checks the addresses the writes would land on.
module tb_spi_slave_ctrl;

   logic       SCLK, RST, SS, counter_tick;
   logic [7:0] Data_sh;
   logic       Address_en, Wr_Data_en, incr_sel, Rd_EN, Load_rd, Busy, Err;

   int n_chk = 0;
   int n_err = 0;

`ifdef SPI_CTRL_ERR_EN
   localparam logic EE = 1'b1;
`else
   localparam logic EE = 1'b0;
`endif

   // strobe vector order: {Address_en, Wr_Data_en, incr_sel, Rd_EN, Load_rd}
   localparam logic [4:0] NO = 5'b00000;
   localparam logic [4:0] AE = 5'b10000;
   localparam logic [4:0] WD = 5'b01000;
   localparam logic [4:0] IN = 5'b00100;
   localparam logic [4:0] RD = 5'b00010;
   localparam logic [4:0] LD = 5'b00001;

   logic [4:0] strb;
   assign strb = {Address_en, Wr_Data_en, incr_sel, Rd_EN, Load_rd};

   spi_slave_ctrl dut (
      .SCLK(SCLK), .RST(RST), .SS(SS), .counter_tick(counter_tick),
      .Data_sh(Data_sh), .Address_en(Address_en), .Wr_Data_en(Wr_Data_en),
      .incr_sel(incr_sel), .Rd_EN(Rd_EN), .Load_rd(Load_rd), .Busy(Busy),
      .Err(Err)
   );

   initial SCLK = 1'b0;
   always #5 SCLK = ~SCLK;

   // Datapath address model: capture, increment, log write addresses.
   logic [7:0] m_addr = 8'h00;
   logic [7:0] wq[$];
   always @(posedge SCLK) begin
      if (RST) begin
         if (Address_en) m_addr <= Data_sh;
         else if (incr_sel) m_addr <= m_addr + 8'h01;
         if (Wr_Data_en) wq.push_back(m_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, sample mid-cycle, move to next negedge.
   task automatic step(input logic ss, input logic tk, input logic [7:0] d,
                       input string tag, input logic [4:0] es, input logic eb);
      SS = ss; counter_tick = tk; Data_sh = d;
      #2;
      chk({tag, "_strb"}, 32'(strb), 32'(es));
      chk({tag, "_busy"}, 32'(Busy), 32'(eb));
      @(negedge SCLK);
   endtask

   // One 4-cycle byte: phase 1, phase 2, phase 3, tick.
   task automatic tx_byte(input string tag, input logic [7:0] d,
                          input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] et);
      step(1'b0, 1'b0, d, {tag, "_p1"}, e1, 1'b1);
      step(1'b0, 1'b0, d, {tag, "_p2"}, e2, 1'b1);
      step(1'b0, 1'b0, d, {tag, "_p3"}, NO, 1'b1);
      step(1'b0, 1'b1, d, {tag, "_tk"}, et, 1'b1);
   endtask

   task automatic start(input string tag);
      step(1'b0, 1'b0, 8'h00, {tag, "_idle"}, NO, 1'b0);
   endtask

   task automatic finish_ss(input string tag);
      step(1'b1, 1'b0, 8'h00, {tag, "_ssr"}, NO, 1'b1);
      step(1'b1, 1'b0, 8'h00, {tag, "_off"}, NO, 1'b0);
   endtask

   initial begin
      RST = 1'b0; SS = 1'b1; counter_tick = 1'b0; Data_sh = 8'h00;
      repeat (2) @(negedge SCLK);
      // Reset state, with a tick and select asserted to show both are ignored.
      SS = 1'b0; counter_tick = 1'b1;
      #2;
      chk("rst_strb", 32'(strb), 32'(NO));
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_err", 32'(Err), 0);
      @(negedge SCLK);
      RST = 1'b1;
      step(1'b1, 1'b0, 8'h00, "pre", NO, 1'b0);

      // Burst write: cmd C2 (N=3), addr 10.
      wq.delete();
      start("bw");
      tx_byte("bw_cmd", 8'hC2, NO, NO, NO);
      tx_byte("bw_adr", 8'h10, NO, NO, AE);
      tx_byte("bw_d1", 8'hA1, NO, NO, WD);
      tx_byte("bw_d2", 8'hA2, IN, NO, WD);
      tx_byte("bw_d3", 8'hA3, IN, NO, WD);
      step(1'b0, 1'b0, 8'h00, "bw_done", NO, 1'b1);
      chk("bw_err", 32'(Err), 0);
      finish_ss("bw");
      chk("bw_nwr", 32'(wq.size()), 3);
      if (wq.size() == 3) begin
         chk("bw_wa0", 32'(wq[0]), 32'h10);
         chk("bw_wa1", 32'(wq[1]), 32'h11);
         chk("bw_wa2", 32'(wq[2]), 32'h12);
      end

      // Single read: cmd 00, addr 3F.
      start("sr");
      tx_byte("sr_cmd", 8'h00, NO, NO, NO);
      tx_byte("sr_adr", 8'h3F, NO, NO, AE);
      tx_byte("sr_dum", 8'h00, RD, NO, LD);
      tx_byte("sr_d1", 8'h00, NO, NO, NO);
      step(1'b0, 1'b0, 8'h00, "sr_done", NO, 1'b1);
      finish_ss("sr");
      chk("sr_addr", 32'(m_addr), 32'h3F);

      // Burst read: cmd 41 (N=2), addr FF wraps to 00.
      start("br");
      tx_byte("br_cmd", 8'h41, NO, NO, NO);
      tx_byte("br_adr", 8'hFF, NO, NO, AE);
      tx_byte("br_dum", 8'h00, RD, NO, LD);
      tx_byte("br_d1", 8'h00, IN, RD, LD);
      tx_byte("br_d2", 8'h00, NO, NO, NO);
      step(1'b0, 1'b0, 8'h00, "br_done", NO, 1'b1);
      finish_ss("br");
      chk("br_addr", 32'(m_addr), 32'h00);

      // Abort: cmd C3, SS rises in WR_INC after second data tick.
      start("ab");
      tx_byte("ab_cmd", 8'hC3, NO, NO, NO);
      tx_byte("ab_adr", 8'h40, NO, NO, AE);
      tx_byte("ab_d1", 8'h01, NO, NO, WD);
      tx_byte("ab_d2", 8'h02, IN, NO, WD);
      step(1'b1, 1'b0, 8'h00, "ab_ss", NO, 1'b1);
      step(1'b1, 1'b0, 8'h00, "ab_idle", NO, 1'b0);
      chk("ab_err", 32'(Err), 32'(EE));
      step(1'b1, 1'b1, 8'h00, "ab_quiet", NO, 1'b0);
      chk("ab_err_hold", 32'(Err), 32'(EE));

      // Overrun: single write cmd 80, then two extra bytes.
      wq.delete();
      start("ov");
      tx_byte("ov_cmd", 8'h80, NO, NO, NO);
      chk("ov_err_clr", 32'(Err), 0);
      tx_byte("ov_adr", 8'h05, NO, NO, AE);
      tx_byte("ov_d1", 8'h11, NO, NO, WD);
      chk("ov_err_pre", 32'(Err), 0);
      tx_byte("ov_x1", 8'h22, NO, NO, NO);
      chk("ov_err", 32'(Err), 32'(EE));
      tx_byte("ov_x2", 8'h33, NO, NO, NO);
      finish_ss("ov");
      chk("ov_nwr", 32'(wq.size()), 1);

      // Reset in WR_INC, then a clean single write.
      start("rm");
      tx_byte("rm_cmd", 8'hC2, NO, NO, NO);
      tx_byte("rm_adr", 8'h10, NO, NO, AE);
      tx_byte("rm_d1", 8'hA1, NO, NO, WD);
      RST = 1'b0;
      step(1'b0, 1'b0, 8'h00, "rm_rst", NO, 1'b0);
      chk("rm_rst_err", 32'(Err), 0);
      RST = 1'b1;
      wq.delete();
      step(1'b0, 1'b0, 8'h00, "rm_idle", NO, 1'b0);
      tx_byte("rm_cmd2", 8'h80, NO, NO, NO);
      tx_byte("rm_adr2", 8'h20, NO, NO, AE);
      tx_byte("rm_d2", 8'h55, NO, NO, WD);
      step(1'b0, 1'b0, 8'h00, "rm_done", NO, 1'b1);
      finish_ss("rm");
      chk("rm_nwr", 32'(wq.size()), 1);
      if (wq.size() == 1) chk("rm_wa", 32'(wq[0]), 32'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
Transaction controller FSM for the SPI slave datapath. It decodes the command byte and sequences the address, write and read phases. It drives the address-capture, write-capture, address-increment, register-read and read-load strobes.
Frame boundaries come from the datapath's byte-tick. Sits between the bit counter/shift register and the register-file interface; clocked by SCLK.

Parameters:
WIDTH, 8, byte/address/data width; must be >= 4
LEN_W, WIDTH-2, width of the burst-length field in the command byte

Ports:
SCLK  input  1  system clock (SPI serial clock)
RST  input  1  synchronous active-low reset
SS  input  1  slave select, active low, sampled on SCLK
counter_tick  input  1  high one cycle when a complete byte is present on Data_sh
Data_sh  input  WIDTH  parallel byte from shift register
Address_en  output  1  capture Data_sh as address
Wr_Data_en  output  1  capture Data_sh as write data
incr_sel  output  1  increment address
Rd_EN  output  1  register-file read request
Load_rd  output  1  load read-data holding register into shift register
Busy  output  1  transaction in progress (state != IDLE)
Err  output  1  protocol error flag (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-low: RST=0 at a SCLK rising edge forces IDLE. Also clears the command fields, remaining count and read phase. All outputs are 0 during and after reset.
- Outputs are decoded combinationally from registered state, phase and counter_tick. Strobes are single-cycle.
- Command byte:
  - bit[WIDTH-1] = 1 write, 0 read.
  - bit[WIDTH-2] = burst.
  - bits[LEN_W-1:0] = len.
  - Byte count N = burst ? len+1 : 1. A remaining register is loaded with N-1.
- States: IDLE, CMD, ADDR, WR_DATA, WR_INC, RD_DUMMY, RD_DATA, DONE.
- SS=1 in any state: next state IDLE, no strobes that cycle. A partial byte is discarded. Priority: RST > SS > other transitions.
- IDLE: SS=0 -> CMD.
- CMD: on tick, latch command -> ADDR.
- ADDR: on tick, Address_en=1. Next state: write -> WR_DATA, read -> RD_DUMMY.
- WR_DATA: on tick, Wr_Data_en=1.
  - remaining==0 -> DONE.
  - Otherwise -> WR_INC.
- WR_INC: incr_sel=1 for exactly one cycle, remaining decrements -> WR_DATA.
  - incr_sel is one cycle after Wr_Data_en, so the datapath's registered Wr_EN still writes the old address.
- RD_DUMMY: one turnaround byte.
  - Cycle after entry (phase 1): Rd_EN=1, no increment; read data is valid in the holding register next cycle.
  - On tick: Load_rd=1 -> RD_DATA.
- RD_DATA, per byte:
  - If remaining != 0: cycle after the byte's start (phase 1) incr_sel=1; phase 2 Rd_EN=1. On tick: Load_rd=1, remaining decrements, stay.
  - If remaining == 0: on tick -> DONE, no Load_rd.
- Minimum byte length is 4 cycles (WIDTH >= 4) so phases 1-2 complete before the tick.
- DONE: ticks are ignored with no strobes. Stays until SS=1.
- Address wrap-around (all-ones -> 0) is the datapath's behaviour; the controller does not track it.
- Tick during reset: ignored.

Optional Feature:
SPI_CTRL_ERR_EN
- Defined: Err is a sticky flag set on either event:
  - a counter_tick in DONE (master overrun);
  - SS rising while in ADDR, WR_DATA, WR_INC, RD_DUMMY or RD_DATA (truncated transaction).
  - Err clears only on reset or on the next IDLE->CMD transition.
- Undefined: Err is tied to 0 and no error logic is synthesized. All other behaviour is identical.

Test Plan:
- Burst write: cmd 0xC2, addr 0x10, data 0xA1,0xA2,0xA3 -> Address_en at tick 2; Wr_Data_en at ticks 3,4,5; incr_sel one cycle after ticks 3 and 4 only; datapath writes 0x10/0x11/0x12; DONE, Busy=1 until SS=1.
- Single read: cmd 0x00, addr 0x3F, dummy, 1 data byte -> Rd_EN once (cycle after tick 2), no incr_sel; Load_rd at tick 3 only; DONE after tick 4.
- Burst read: cmd 0x41 (N=2), addr 0xFF -> Rd_EN after tick 2 and in phase 2 of byte 4; incr_sel once; Load_rd at ticks 3 and 4; address wraps to 0x00.
- Abort: SS=1 one cycle after second write-data tick of cmd 0xC3 -> IDLE next cycle, no further strobes; Err=1 only with SPI_CTRL_ERR_EN.
- Overrun: cmd 0x80 (single write), then 2 extra data bytes -> exactly one Wr_Data_en, extra ticks produce no strobes; Err=1 with macro, 0 without.
- Reset mid-burst: RST=0 in WR_INC -> all outputs 0 next edge, state IDLE; after RST=1 with SS low, a new transaction starts cleanly from CMD.
